// File: rtl/seq_counter_ctrl.sv
// -----------------------------------------------------------------------------
// seq_counter_ctrl
//   Sequence counter and run-control for the multi-cycle 16-bit RISC control
//   unit. It produces the 3-bit timing count and the enable for the 3-to-8
//   decoder that generates the timing strobes T0..T7. It also handles:
//     - start and halt,
//     - single-step mode,
//     - memory stall,
//     - end-of-instruction clear,
//     - runaway-count detection.
//
// Ports
//   CLK        in   system clock, rising-edge active
//   RST_N      in   synchronous reset, active-low
//   START      in   pulse, start execution from T0 (IDLE only)
//   HLT        in   halt request (acts only while running)
//   SC_CLR     in   end of instruction, counter returns to T0
//   STALL      in   memory not ready, hold the current timing state
//   STEP_MODE  in   level, stop after every completed instruction
//   STEP       in   pulse, run one instruction while STEP_MODE=1
//   A0,A1,A2   out  counter bits SC[0..2] to the decoder address inputs
//   EN         out  decoder enable (run flip-flop S)
//   INST_DONE  out  one-cycle pulse after an accepted SC_CLR
//   SEQ_ERR    out  sticky runaway-count flag
//   RUNNING    out  copy of S for the console
//
// All outputs are registers or direct copies of registers.
// -----------------------------------------------------------------------------
module seq_counter_ctrl #(
    parameter int SC_W  = 3,  // fixed by the 3-to-8 decoder
    parameter int MAX_T = 7   // last legal timing state
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic START,
    input  logic HLT,
    input  logic SC_CLR,
    input  logic STALL,
    input  logic STEP_MODE,
    input  logic STEP,
    output logic A0,
    output logic A1,
    output logic A2,
    output logic EN,
    output logic INST_DONE,
    output logic SEQ_ERR,
    output logic RUNNING
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN      = 2'b01,
        STEP_RUN = 2'b10
    } state_t;

    localparam logic [SC_W-1:0] SC_ZERO = {SC_W{1'b0}};
    localparam logic [SC_W-1:0] SC_ONE  = {{(SC_W-1){1'b0}}, 1'b1};
    localparam logic [SC_W-1:0] SC_LAST = MAX_T[SC_W-1:0];

    state_t          state_r, state_s;
    logic [SC_W-1:0] sc_r, sc_s;
    logic            run_r, run_s;
    logic            done_r, done_s;
    logic            err_r, err_s;

    // Next-state, counter and flag computation.
    always_comb begin
        state_s = state_r;
        sc_s    = sc_r;
        done_s  = 1'b0;
        err_s   = err_r;

        case (state_r)
            IDLE: begin
                // Counter is parked at T0 so the first strobe after a start is T0.
                sc_s = SC_ZERO;
                if (START == 1'b1) begin
                    if (STEP_MODE == 1'b1) begin
                        state_s = STEP_RUN;
                    end else begin
                        state_s = RUN;
                    end
                end else if ((STEP == 1'b1) && (STEP_MODE == 1'b1)) begin
                    state_s = STEP_RUN;
                end else begin
                    state_s = IDLE;
                end
            end

            RUN, STEP_RUN: begin
                if (HLT == 1'b1) begin
                    // Halt beats clear: no INST_DONE for a halted instruction.
                    state_s = IDLE;
                    sc_s    = SC_ZERO;
                end else if (SC_CLR == 1'b1) begin
                    sc_s   = SC_ZERO;
                    done_s = 1'b1;
                    // Stop after this instruction when single-stepping, or when
                    // step mode was switched on during a free run.
                    if ((state_r == STEP_RUN) || (STEP_MODE == 1'b1)) begin
                        state_s = IDLE;
                    end else begin
                        state_s = state_r;
                    end
                end else if (STALL == 1'b1) begin
                    sc_s = sc_r;
                end else if (sc_r == SC_LAST) begin
                    // Runaway: no clear by the last timing state. Wrap and flag.
                    sc_s  = SC_ZERO;
                    err_s = 1'b1;
                end else begin
                    sc_s = sc_r + SC_ONE;
                end
            end

            default: begin
                state_s = IDLE;
                sc_s    = SC_ZERO;
            end
        endcase

        run_s = (state_s != IDLE);
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (RST_N == 1'b0) begin
            state_r <= IDLE;
            sc_r    <= SC_ZERO;
            run_r   <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            sc_r    <= sc_s;
            run_r   <= run_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

    assign A0        = sc_r[0];
    assign A1        = sc_r[1];
    assign A2        = sc_r[2];
    assign EN        = run_r;
    assign RUNNING   = run_r;
    assign INST_DONE = done_r;
    assign SEQ_ERR   = err_r;

endmodule
